// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, memory-stage and RAM-side signals around the main RAM arbiter.
// The slave modport is the arbiter's view; the master modport is the view of the
// pipeline stages and RAM macro that surround it.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 11
) ();
    logic              if_req;
    logic [31:0]       if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [31:0]       if_rdata;
    logic              if_stall;

    logic              ls_req;
    logic              ls_we;
    logic [31:0]       ls_addr;
    logic [31:0]       ls_wdata;
    logic              ls_gnt;
    logic              ls_rvalid;
    logic [31:0]       ls_rdata;
    logic              ls_stall;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata, if_stall,
        input  ls_req, ls_we, ls_addr, ls_wdata,
        output ls_gnt, ls_rvalid, ls_rdata, ls_stall,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata, if_stall,
        output ls_req, ls_we, ls_addr, ls_wdata,
        input  ls_gnt, ls_rvalid, ls_rdata, ls_stall,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbiter for the single-port main RAM shared by the fetch stage and the memory stage.
// One access in flight at a time; reads hold the port for RD_LAT+1 cycles, stores for one.
// Memory stage has priority, except that fetch wins once the memory stage has taken
// MAX_LS_STREAK consecutive grants while fetch was waiting.
// Grants, RAM strobes and stalls are decoded combinationally from the registered state
// so a request can be granted in the cycle it appears; every output is forced low
// while rst_n is asserted.
module mem_port_arbiter #(
    parameter int ADDR_W        = 11,
    parameter int RD_LAT        = 1,
    parameter int MAX_LS_STREAK = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_port_arbiter_if.slave  bus
);

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } state_t;

    localparam logic [2:0] LAT_C    = 3'(RD_LAT);
    localparam logic [3:0] STREAK_C = 4'(MAX_LS_STREAK);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [3:0]  streak_q, streak_d;
    logic        owner_ls_q, owner_ls_d;

    logic        grant_if;
    logic        grant_ls;
    logic        read_done;
    logic        fetch_waits_behind_ls;
    logic [31:0] sel_addr;

    // Same-cycle arbitration in IDLE: memory stage first unless fetch has been starved
    always_comb begin
        grant_if = 1'b0;
        grant_ls = 1'b0;
        fetch_waits_behind_ls = bus.if_req && (streak_q == STREAK_C);
        if (state_q == IDLE) begin
            if (bus.ls_req && !fetch_waits_behind_ls) begin
                grant_ls = 1'b1;
            end else if (bus.if_req) begin
                grant_if = 1'b1;
            end
        end
    end

    assign read_done = (state_q == READ) && (cnt_q == LAT_C);

    // Next-state, latency counter, owner and starvation-streak bookkeeping
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        streak_d   = streak_q;
        owner_ls_d = owner_ls_q;

        case (state_q)
            IDLE: begin
                if (grant_if || (grant_ls && !bus.ls_we)) begin
                    state_d    = READ;
                    cnt_d      = 3'd1;
                    owner_ls_d = grant_ls;
                end
            end
            READ: begin
                if (read_done) begin
                    state_d = IDLE;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 3'd0;
            end
        endcase

        if (grant_ls) begin
            if (bus.if_req) begin
                streak_d = (streak_q == STREAK_C) ? STREAK_C : streak_q + 4'd1;
            end else begin
                streak_d = 4'd0;
            end
        end else if (grant_if) begin
            streak_d = 4'd0;
        end
    end

    // Single state register; asynchronous reset abandons any read in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            streak_q   <= 4'd0;
            owner_ls_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            streak_q   <= streak_d;
            owner_ls_q <= owner_ls_d;
        end
    end

    assign sel_addr = grant_ls ? bus.ls_addr : bus.if_addr;

    assign bus.if_gnt    = rst_n && grant_if;
    assign bus.ls_gnt    = rst_n && grant_ls;

    assign bus.mem_en    = rst_n && (grant_if || grant_ls);
    assign bus.mem_we    = rst_n && grant_ls && bus.ls_we;
    assign bus.mem_addr  = bus.mem_en ? sel_addr[ADDR_W+1:2] : '0;
    assign bus.mem_wdata = bus.mem_we ? bus.ls_wdata : 32'h0;

    assign bus.if_rvalid = rst_n && read_done && !owner_ls_q;
    assign bus.ls_rvalid = rst_n && read_done &&  owner_ls_q;
    assign bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : 32'h0;
    assign bus.ls_rdata  = bus.ls_rvalid ? bus.mem_rdata : 32'h0;

    assign bus.if_stall  = rst_n && ((bus.if_req && !grant_if) || grant_if ||
                                     ((state_q == READ) && !owner_ls_q && !read_done));
    assign bus.ls_stall  = rst_n && ((bus.ls_req && !grant_ls) || (grant_ls && !bus.ls_we) ||
                                     ((state_q == READ) && owner_ls_q && !read_done));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with RD_LAT=3 and MAX_LS_STREAK=4.
// Directed scenarios push the hand-computed grant and read-data events they expect;
// a negedge monitor pops and compares whenever the arbiter grants or returns data.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 11;
    localparam int LAT    = 3;
    localparam int MAXS   = 4;

    typedef struct {
        int          cyc;
        bit          is_ls;
        bit          we;
        logic [10:0] addr;
        logic [31:0] wdata;
    } gnt_exp_t;

    typedef struct {
        int          cyc;
        bit          is_ls;
        logic [31:0] data;
    } rd_exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   failures;

    gnt_exp_t gnt_q[$];
    rd_exp_t  rd_q[$];

    logic [31:0] ram  [0:2047];
    logic [31:0] pipe [0:LAT-1];

    mem_port_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    mem_port_arbiter #(
        .ADDR_W(ADDR_W),
        .RD_LAT(LAT),
        .MAX_LS_STREAK(MAXS)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter: cycle N lasts from the Nth rising edge to the next one
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM macro model: preload at the first edge, then write on enable, read with LAT-cycle pipeline
    always @(posedge clk) begin
        if (cyc == 0) begin
            ram[4] <= 32'hE3A01005;
            ram[5] <= 32'h11112222;
            ram[6] <= 32'h55556666;
            ram[7] <= 32'h77778888;
            ram[9] <= 32'h33334444;
        end else if (bus.mem_en && bus.mem_we) begin
            ram[bus.mem_addr] <= bus.mem_wdata;
        end
        pipe[0] <= (bus.mem_en && !bus.mem_we) ? ram[bus.mem_addr] : 32'h0;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign bus.mem_rdata = pipe[LAT-1];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, actual, expected);
        end
    endtask

    task automatic reportFail(input string name, input int detail);
        checks++;
        failures++;
        $display("[TB] FAIL %s cycle=%0d actual=event expected=%0d", name, cyc, detail);
    endtask

    task automatic applyStimulus(input logic ir, input logic [31:0] ia, input logic lr,
                                 input logic lw, input logic [31:0] la, input logic [31:0] ld);
        bus.if_req   = ir;
        bus.if_addr  = ia;
        bus.ls_req   = lr;
        bus.ls_we    = lw;
        bus.ls_addr  = la;
        bus.ls_wdata = ld;
    endtask

    task automatic expectGnt(input int c, input bit is_ls, input bit we,
                             input logic [10:0] addr, input logic [31:0] wdata);
        gnt_exp_t g;
        g.cyc = c; g.is_ls = is_ls; g.we = we; g.addr = addr; g.wdata = wdata;
        gnt_q.push_back(g);
    endtask

    task automatic expectRead(input int c, input bit is_ls, input logic [31:0] data);
        rd_exp_t r;
        r.cyc = c; r.is_ls = is_ls; r.data = data;
        rd_q.push_back(r);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every grant or rvalid must match the head of its expectation queue
    always @(negedge clk) begin
        gnt_exp_t g;
        rd_exp_t  r;
        if (bus.if_gnt && bus.ls_gnt) reportFail("dual_gnt", 0);
        if (bus.if_gnt || bus.ls_gnt) begin
            if (gnt_q.size() == 0) begin
                reportFail("gnt_unexpected", -1);
            end else begin
                g = gnt_q.pop_front();
                checkOutput("gnt_cycle", cyc, g.cyc);
                checkOutput("gnt_is_ls", {31'b0, bus.ls_gnt}, {31'b0, g.is_ls});
                checkOutput("gnt_mem_en", {31'b0, bus.mem_en}, 32'd1);
                checkOutput("gnt_mem_we", {31'b0, bus.mem_we}, {31'b0, g.we});
                checkOutput("gnt_mem_addr", {21'b0, bus.mem_addr}, {21'b0, g.addr});
                if (g.we) checkOutput("gnt_mem_wdata", bus.mem_wdata, g.wdata);
            end
        end
        if (bus.if_rvalid || bus.ls_rvalid) begin
            if (rd_q.size() == 0) begin
                reportFail("rvalid_unexpected", -1);
            end else begin
                r = rd_q.pop_front();
                checkOutput("rd_cycle", cyc, r.cyc);
                checkOutput("rd_is_ls", {31'b0, bus.ls_rvalid}, {31'b0, r.is_ls});
                checkOutput("rd_data", r.is_ls ? bus.ls_rdata : bus.if_rdata, r.data);
            end
        end
        if (!bus.if_rvalid) checkOutput("if_rdata_idle", bus.if_rdata, 32'h0);
        if (!bus.ls_rvalid) checkOutput("ls_rdata_idle", bus.ls_rdata, 32'h0);
    end

    // Directed scenarios
    initial begin
        int c;
        checks   = 0;
        failures = 0;

        // Reset with both requests high: everything must stay at 0
        rst_n = 1'b0;
        applyStimulus(1'b1, 32'h10, 1'b1, 1'b0, 32'h20, 32'h0);
        #2;
        checkOutput("rst_if_gnt",   {31'b0, bus.if_gnt},   32'd0);
        checkOutput("rst_ls_gnt",   {31'b0, bus.ls_gnt},   32'd0);
        checkOutput("rst_if_stall", {31'b0, bus.if_stall}, 32'd0);
        checkOutput("rst_ls_stall", {31'b0, bus.ls_stall}, 32'd0);
        checkOutput("rst_mem_en",   {31'b0, bus.mem_en},   32'd0);
        checkOutput("rst_mem_addr", {21'b0, bus.mem_addr}, 32'd0);
        nextCycle();
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        rst_n = 1'b1;
        nextCycle();

        // Lone fetch read of word 4
        c = cyc;
        applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0);
        expectGnt(c, 1'b0, 1'b0, 11'd4, 32'h0);
        expectRead(c + LAT, 1'b0, 32'hE3A01005);
        for (int k = 0; k <= LAT; k++) begin
            if (k == 1) bus.if_req = 1'b0;
            @(negedge clk);
            checkOutput("s1_if_stall", {31'b0, bus.if_stall}, {31'b0, (k < LAT)});
            nextCycle();
        end

        // Lone store, then an immediate load of the same address
        c = cyc;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h20, 32'hDEADBEEF);
        expectGnt(c, 1'b1, 1'b1, 11'd8, 32'hDEADBEEF);
        expectGnt(c + 1, 1'b1, 1'b0, 11'd8, 32'h0);
        expectRead(c + 1 + LAT, 1'b1, 32'hDEADBEEF);
        @(negedge clk);
        checkOutput("s2_store_ls_stall", {31'b0, bus.ls_stall}, 32'd0);
        nextCycle();
        bus.ls_we = 1'b0;
        @(negedge clk);
        checkOutput("s2_load_ls_stall", {31'b0, bus.ls_stall}, 32'd1);
        nextCycle();
        bus.ls_req = 1'b0;
        repeat (LAT) nextCycle();

        // Simultaneous fetch and load: load first, fetch after the load completes
        c = cyc;
        applyStimulus(1'b1, 32'h14, 1'b1, 1'b0, 32'h24, 32'h0);
        expectGnt(c, 1'b1, 1'b0, 11'd9, 32'h0);
        expectRead(c + LAT, 1'b1, 32'h33334444);
        expectGnt(c + LAT + 1, 1'b0, 1'b0, 11'd5, 32'h0);
        expectRead(c + 2 * LAT + 1, 1'b0, 32'h11112222);
        for (int k = 0; k <= 2 * LAT + 1; k++) begin
            if (k == 1) bus.ls_req = 1'b0;
            if (k == LAT + 2) bus.if_req = 1'b0;
            @(negedge clk);
            checkOutput("s3_if_stall", {31'b0, bus.if_stall}, {31'b0, (k < 2 * LAT + 1)});
            nextCycle();
        end

        // Starvation guard: four stores while fetch waits, then fetch, then ls wins again
        c = cyc;
        for (int k = 0; k < 4; k++)
            expectGnt(c + k, 1'b1, 1'b1, 11'(16 + k), 32'hA0000000 + 32'(k));
        expectGnt(c + 4, 1'b0, 1'b0, 11'd6, 32'h0);
        expectRead(c + 4 + LAT, 1'b0, 32'h55556666);
        expectGnt(c + 5 + LAT, 1'b1, 1'b1, 11'd20, 32'hA0000004);
        expectGnt(c + 6 + LAT, 1'b0, 1'b0, 11'd7, 32'h0);
        expectRead(c + 6 + 2 * LAT, 1'b0, 32'h77778888);
        for (int k = 0; k <= 7 + 2 * LAT; k++) begin
            applyStimulus((k <= 4) || (k == 5 + LAT) || (k == 6 + LAT),
                          (k <= 4) ? 32'h18 : 32'h1C,
                          (k <= 5 + LAT), 1'b1,
                          (k < 4) ? 32'h40 + 32'(4 * k) : 32'h50,
                          32'hA0000000 + 32'((k < 4) ? k : 4));
            nextCycle();
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        nextCycle();

        // Load in flight blocks a fetch raised one cycle later
        c = cyc;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0);
        expectGnt(c, 1'b1, 1'b0, 11'd8, 32'h0);
        expectRead(c + LAT, 1'b1, 32'hDEADBEEF);
        expectGnt(c + LAT + 1, 1'b0, 1'b0, 11'd4, 32'h0);
        expectRead(c + 2 * LAT + 1, 1'b0, 32'hE3A01005);
        nextCycle();
        applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("s5_read_mem_en", {31'b0, bus.mem_en},   32'd0);
        checkOutput("s5_if_stall",    {31'b0, bus.if_stall}, 32'd1);
        repeat (LAT) nextCycle();
        nextCycle();
        bus.if_req = 1'b0;
        repeat (LAT + 1) nextCycle();

        // Reset in the middle of a load: no data afterwards, then normal service
        c = cyc;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h24, 32'h0);
        expectGnt(c, 1'b1, 1'b0, 11'd9, 32'h0);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        rst_n = 1'b0;
        #1;
        checkOutput("s6_rst_ls_stall",  {31'b0, bus.ls_stall},  32'd0);
        checkOutput("s6_rst_ls_rvalid", {31'b0, bus.ls_rvalid}, 32'd0);
        checkOutput("s6_rst_mem_en",    {31'b0, bus.mem_en},    32'd0);
        repeat (LAT) nextCycle();
        rst_n = 1'b1;
        nextCycle();
        c = cyc;
        applyStimulus(1'b1, 32'h14, 1'b0, 1'b0, 32'h0, 32'h0);
        expectGnt(c, 1'b0, 1'b0, 11'd5, 32'h0);
        expectRead(c + LAT, 1'b0, 32'h11112222);
        nextCycle();
        bus.if_req = 1'b0;
        repeat (LAT + 3) nextCycle();

        // Anything still queued was never presented by the arbiter
        while (gnt_q.size() > 0) reportFail("gnt_missing", gnt_q.pop_front().cyc);
        while (rd_q.size() > 0)  reportFail("rvalid_missing", rd_q.pop_front().cyc);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
